// File: rtl/sweep_ctrl.sv
// Triangle-sweep sequencer for an external up/down counter, with a start/ready/done host handshake.
// Optional counter-tracking check enabled by defining SWEEP_CHECK_EN.
module sweep_ctrl #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned REP_W = 4
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic [WIDTH-1:0] target,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
    input  logic [WIDTH-1:0] cnt_q,
    output logic             cnt_clr,
    output logic             cnt_up,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [REP_W-1:0] sweeps_left,
    output logic             err
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StUp   = 2'd1,
        StDown = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_d;
    logic [WIDTH-1:0] r_target;
    logic [WIDTH-1:0] w_target_d;
    logic [REP_W-1:0] r_sweeps_left;
    logic [REP_W-1:0] w_sweeps_d;
    logic             r_done;
    logic             w_done_d;
    logic             w_err;
    logic             w_mismatch;
    logic             w_accept;
    logic             w_busy;
    logic [WIDTH-1:0] w_peak_turn;

    assign w_busy      = (r_state == StUp) || (r_state == StDown);
    assign w_accept    = start && ready && !abort;
    // Turn one count early: the counter lands on the peak at the same edge we switch direction.
    assign w_peak_turn = r_target - WIDTH'(1);

`ifdef SWEEP_CHECK_EN
    logic             r_err;
    logic [WIDTH-1:0] r_shadow;

    assign w_mismatch = w_busy && (cnt_q != r_shadow);
    assign w_err      = r_err;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_shadow <= '0;
            r_err    <= 1'b0;
        end else begin
            if (r_state == StUp) begin
                r_shadow <= r_shadow + WIDTH'(1);
            end else if (r_state == StDown) begin
                r_shadow <= r_shadow - WIDTH'(1);
            end else begin
                r_shadow <= '0;
            end
            if (w_mismatch) begin
                r_err <= 1'b1;
            end
        end
    end
`else
    assign w_mismatch = 1'b0;
    assign w_err      = 1'b0;
`endif

    always_comb begin
        w_state_d  = r_state;
        w_target_d = r_target;
        w_sweeps_d = r_sweeps_left;
        w_done_d   = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if ((target != '0) && (reps != '0)) begin
                        w_target_d = target;
                        w_sweeps_d = reps;
                        w_state_d  = StUp;
                    end else begin
                        w_done_d = 1'b1;
                    end
                end
            end
            StUp: begin
                if (abort || w_mismatch) begin
                    w_state_d  = StIdle;
                    w_sweeps_d = '0;
                end else if (cnt_q == w_peak_turn) begin
                    w_state_d = StDown;
                end
            end
            StDown: begin
                if (abort || w_mismatch) begin
                    w_state_d  = StIdle;
                    w_sweeps_d = '0;
                end else if (cnt_q == WIDTH'(1)) begin
                    if (r_sweeps_left > REP_W'(1)) begin
                        w_sweeps_d = r_sweeps_left - REP_W'(1);
                        w_state_d  = StUp;
                    end else begin
                        w_sweeps_d = '0;
                        w_state_d  = StIdle;
                        w_done_d   = 1'b1;
                    end
                end
            end
            default: begin
                w_state_d  = StIdle;
                w_sweeps_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state       <= StIdle;
            r_target      <= '0;
            r_sweeps_left <= '0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_state_d;
            r_target      <= w_target_d;
            r_sweeps_left <= w_sweeps_d;
            r_done        <= w_done_d;
        end
    end

    assign cnt_clr     = (r_state == StIdle);
    assign cnt_up      = (r_state != StDown);
    assign ready       = (r_state == StIdle) && !w_err;
    assign busy        = w_busy;
    assign done        = r_done;
    assign sweeps_left = r_sweeps_left;
    assign err         = w_err;

endmodule

// File: tb/tb_sweep_ctrl.sv
// Self-checking bench for sweep_ctrl: a behavioural counter beside the DUT and an arithmetic
// triangle-waveform reference for directed and random sweeps.
module tb_sweep_ctrl;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic [3:0] target = 4'd0;
    logic [3:0] reps = 4'd0;
    logic       abort = 1'b0;
    logic [3:0] cnt_q;
    logic       cnt_clr, cnt_up, ready, busy, done, err;
    logic [3:0] sweeps_left;

    logic [3:0] cq = 4'd0;
    logic       fen = 1'b0;
    logic [3:0] fval = 4'd0;

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    // The free-running counter the sequencer drives.
    always_ff @(posedge clk) begin
        if (cnt_clr) cq <= 4'd0;
        else if (cnt_up) cq <= cq + 4'd1;
        else cq <= cq - 4'd1;
    end

    assign cnt_q = fen ? fval : cq;

    sweep_ctrl #(.WIDTH(4), .REP_W(4)) dut (
        .clk(clk), .clr(clr), .start(start), .target(target), .reps(reps), .abort(abort),
        .cnt_q(cnt_q), .cnt_clr(cnt_clr), .cnt_up(cnt_up), .ready(ready), .busy(busy),
        .done(done), .sweeps_left(sweeps_left), .err(err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_ready"}, {31'd0, ready}, 32'd1);
        chk({tag, "_clr"}, {31'd0, cnt_clr}, 32'd1);
        chk({tag, "_done"}, {31'd0, done}, {31'd0, exp_done});
        chk({tag, "_sl"}, {28'd0, sweeps_left}, 32'd0);
    endtask

    // Expected waveform: cycle k of 2*t*r after acceptance sits at phase (k-1) mod 2t of a triangle.
    task automatic run_seq(input int t, input int r);
        int total, p, ec, esl;
        target = 4'(t);
        reps   = 4'(r);
        start  = 1'b1;
        step();
        start  = 1'b0;
        target = 4'($urandom);
        reps   = 4'($urandom);
        if (t == 0 || r == 0) begin
            chk_idle("zero", 1'b1);
            step();
            chk("zero_done_off", {31'd0, done}, 32'd0);
            return;
        end
        total = 2 * t * r;
        for (int k = 1; k <= total; k++) begin
            p   = (k - 1) % (2 * t);
            ec  = (p <= t) ? p : 2 * t - p;
            esl = r - (k - 1) / (2 * t);
            chk("cnt_q", {28'd0, cnt_q}, ec);
            chk("busy", {31'd0, busy}, 32'd1);
            chk("ready_busy", {31'd0, ready}, 32'd0);
            chk("cnt_up", {31'd0, cnt_up}, (p < t) ? 32'd1 : 32'd0);
            chk("cnt_clr_busy", {31'd0, cnt_clr}, 32'd0);
            chk("sweeps_left", {28'd0, sweeps_left}, esl);
            chk("done_early", {31'd0, done}, 32'd0);
            chk("err_busy", {31'd0, err}, 32'd0);
            start  = ($urandom_range(0, 3) == 0);
            target = 4'($urandom);
            reps   = 4'($urandom);
            step();
        end
        start = 1'b0;
        chk_idle("end", 1'b1);
        chk("end_cnt", {28'd0, cnt_q}, 32'd0);
        step();
        chk("end_done_off", {31'd0, done}, 32'd0);
    endtask

    initial begin
        #2 clr = 1'b1;
        #1;
        chk_idle("reset", 1'b0);
        chk("reset_up", {31'd0, cnt_up}, 32'd1);
        chk("reset_err", {31'd0, err}, 32'd0);
        #4 clr = 1'b0;
        step();

        run_seq(3, 1);
        run_seq(2, 3);
        run_seq(15, 1);
        run_seq(0, 5);
        run_seq(3, 0);
        run_seq(1, 2);

        // Abort while ramping up at cnt_q=4.
        target = 4'd5; reps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        chk("abort_pre_cnt", {28'd0, cnt_q}, 32'd4);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_idle("abort", 1'b0);
        step();
        chk("abort_done_off", {31'd0, done}, 32'd0);
        chk("abort_cnt_cleared", {28'd0, cnt_q}, 32'd0);

        // Start and abort together in IDLE: not accepted.
        target = 4'd3; reps = 4'd1; start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk_idle("start_abort", 1'b0);
        step();
        chk_idle("start_abort2", 1'b0);

        for (int i = 0; i < 20; i++) begin
            run_seq($urandom_range(0, 15), $urandom_range(0, 4));
            repeat ($urandom_range(0, 2)) step();
        end

        // Asynchronous reset in the middle of a sequence.
        target = 4'd4; reps = 4'd2; start = 1'b1;
        step();
        start = 1'b0;
        repeat (3) step();
        chk("mid_busy", {31'd0, busy}, 32'd1);
        #3 clr = 1'b1;
        #1;
        chk_idle("async_rst", 1'b0);
        #1 clr = 1'b0;
        step();
        chk_idle("post_rst", 1'b0);
        chk("post_rst_cnt", {28'd0, cnt_q}, 32'd0);

`ifdef SWEEP_CHECK_EN
        target = 4'd5; reps = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        chk("chk_pre_cnt", {28'd0, cnt_q}, 32'd2);
        fen = 1'b1; fval = 4'd7;
        step();
        fen = 1'b0;
        chk("chk_err", {31'd0, err}, 32'd1);
        chk("chk_busy", {31'd0, busy}, 32'd0);
        chk("chk_ready", {31'd0, ready}, 32'd0);
        chk("chk_done", {31'd0, done}, 32'd0);
        chk("chk_sl", {28'd0, sweeps_left}, 32'd0);
        target = 4'd3; reps = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        chk("chk_blocked_busy", {31'd0, busy}, 32'd0);
        chk("chk_blocked_done", {31'd0, done}, 32'd0);
        chk("chk_sticky", {31'd0, err}, 32'd1);
        #2 clr = 1'b1;
        #1;
        chk("chk_rst_err", {31'd0, err}, 32'd0);
        chk("chk_rst_ready", {31'd0, ready}, 32'd1);
        #1 clr = 1'b0;
        step();
`else
        chk("err_tied", {31'd0, err}, 32'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
